div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Iterative radix-2 divider and sequencer for DIV/DIVU, owned by the EX stage.
//  EX raises start_i with operands latched from the ID forwarding outputs.
//  The block runs a restoring shift-subtract loop, one quotient bit per cycle.
//  While busy it raises stallreq_o to the pipeline controller.
//  It returns {remainder, quotient} for the HI/LO write.
// PARAMETERS
//  WIDTH     32   operand width; result_o is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clk          in   1        clock, all state updates on rising edge
//  rst          in   1        reset, asynchronous, active-low (0 = reset)
//  start_i      in   1        divide request; held high by EX until ready_o seen
//  annul_i      in   1        cancel request/operation (branch/flush); wins over start_i
//  signed_i     in   1        1 = DIV (two's complement), 0 = DIVU; sampled at accept
//  dividend_i   in   WIDTH    dividend (rs); sampled at accept
//  divisor_i    in   WIDTH    divisor (rt); sampled at accept
//  result_o     out  2*WIDTH  {remainder -> HI, quotient -> LO}; valid when ready_o=1
//  ready_o      out  1        result valid (END state)
//  stallreq_o   out  1        pipeline stall request to controller
// BEHAVIOUR
//  States: FREE, BYZERO, ON, END. Reset (rst=0, async) -> FREE, cnt=0, result_o=0,
//   ready_o=0, stallreq_o=0 regardless of state; operation in flight is discarded.
//  Accept: in FREE, start_i=1 and annul_i=0 -> latch operands and signed_i.
//   - divisor==0 -> BYZERO; otherwise -> ON with cnt=0.
//   - Signed mode: latch |dividend| and |divisor|, plus sign flags. abs(0x8000_0000)
//     is 0x8000_0000 treated as unsigned.
//  BYZERO: one cycle, then -> END with result_o = 0 (quotient 0, remainder 0).
//  ON: each cycle shift {partial_rem, dividend} left 1. Then trial-subtract the divisor
//   (WIDTH+1-bit subtract). If no borrow, keep the difference and quotient bit=1;
//   else quotient bit=0. cnt++.
//   - After the step with cnt==WIDTH-1 -> END.
//   - Sign fix on entering END: quotient negated if signs differ; remainder takes
//     the dividend's sign.
//  END: ready_o=1, result_o held stable.
//   - Stays in END while start_i=1.
//   - start_i=0 -> FREE; ready_o=0 and result_o=0 the cycle after.
//   - annul_i is ignored in END: the result is already committed.
//  Annul: annul_i=1 in BYZERO or ON -> FREE on the next edge; ready_o never asserted.
//   annul_i=1 in FREE -> no accept.
//  stallreq_o (combinational) = 1 when any of the following holds:
//   - state is FREE and start_i & ~annul_i;
//   - state is BYZERO or ON and ~annul_i.
//   Otherwise 0; it is 0 in END so the pipeline advances exactly once.
//  Latency: accept edge = cycle 0. ready_o=1 at cycle WIDTH+1 (33) for nonzero
//   divisors, at cycle 2 for divide-by-zero.
//  Back-to-back: a new divide requires start_i to drop for at least one cycle (END->FREE).
//  Operand changes on *_i after accept have no effect.
//  Signed overflow 0x8000_0000 / 0xFFFF_FFFF -> quotient 0x8000_0000, remainder 0.
// TESTING
//  1. DIVU 100/7: start at c0 -> stallreq 1 c0..c32, ready c33, result_o={32'd2,32'd14}.
//  2. DIV -7/2 (0xFFFFFFF9/2) -> result_o={32'hFFFFFFFF,32'hFFFFFFFD}.
//     DIV 7/-2 -> {32'd1,32'hFFFFFFFD}.
//  3. Divisor 0 (DIV and DIVU, dividend 0x1234) -> BYZERO, ready at c2, result_o=0.
//  4. annul_i pulse at c10 of DIVU 0xFFFFFFFF/3 -> FREE at c11, ready_o stays 0.
//     A new DIVU 9/3 then gives {0,3} after 33 cycles.
//  5. rst=0 asserted mid-ON (c15, between edges) -> outputs 0 immediately.
//     After release, start is accepted normally from FREE.
//  6. DIV 0x80000000/0xFFFFFFFF -> {0,32'h80000000}. Hold start_i 5 cycles in END:
//     result stable, stallreq 0. Drop start_i -> ready 0 next cycle.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces one quotient bit per cycle and returns {remainder, quotient}.
//
// Ports
//   clk          clock, rising-edge
//   rst          asynchronous reset, active-low
//   start_i      divide request, held until ready_o is seen
//   annul_i      cancel request / in-flight operation (ignored once in END)
//   signed_i     1 = signed divide, 0 = unsigned; sampled at accept
//   dividend_i   dividend, sampled at accept
//   divisor_i    divisor, sampled at accept
//   result_o     {remainder, quotient}, valid while ready_o = 1
//   ready_o      result valid
//   stallreq_o   stall request to the pipeline controller
//
// state  | meaning
// FREE   | idle, waiting for start_i
// BYZERO | divisor was zero, one cycle before returning a zero result
// ON     | shift-subtract iterations in progress
// END    | result committed, held until start_i drops

module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     q_step;
    logic [WIDTH-1:0]     r_step;
    logic [WIDTH-1:0]     q_fix;
    logic [WIDTH-1:0]     r_fix;
    logic                 a_neg;
    logic                 b_neg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        stallreq_o = 1'b0;

        // One restoring step. The partial remainder is always below the
        // divisor, so a (WIDTH+1)-bit subtract suffices and its MSB is the borrow.
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvsr_q};
        q_step = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        r_step = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        q_fix  = neg_quo_q ? -q_step : q_step;
        r_fix  = neg_rem_q ? -r_step : r_step;

        a_neg  = signed_i & dividend_i[WIDTH-1];
        b_neg  = signed_i & divisor_i[WIDTH-1];

        unique case (state_q)
            S_FREE: begin
                if (start_i && !annul_i) begin
                    stallreq_o = 1'b1;
                    rem_d      = '0;
                    // Negating the most negative value wraps to itself, which
                    // is the correct magnitude when read as unsigned.
                    quo_d      = a_neg ? -dividend_i : dividend_i;
                    dvsr_d     = b_neg ? -divisor_i : divisor_i;
                    neg_quo_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    cnt_d      = '0;
                    state_d    = (divisor_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else begin
                    stallreq_o = 1'b1;
                    result_d   = '0;
                    state_d    = S_END;
                end
            end
            S_ON: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else begin
                    stallreq_o = 1'b1;
                    rem_d      = r_step;
                    quo_d      = q_step;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result_d = {r_fix, q_fix};
                        state_d  = S_END;
                    end
                end
            end
            S_END: begin
                if (!start_i) begin
                    result_d = '0;
                    state_d  = S_FREE;
                end
            end
            default: state_d = S_FREE;
        endcase

        // Stall must read 0 while reset is asserted, even with start_i high.
        if (!rst) begin
            stallreq_o = 1'b0;
        end
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == S_END);

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic           annul_i;
    logic           signed_i;
    logic [W-1:0]   dividend_i;
    logic [W-1:0]   divisor_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           stallreq_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference: plain integer division, truncating toward zero,
    // remainder carrying the dividend's sign; zero divisor gives zero.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        int ia, ib;
        if (b == 0) return 64'd0;
        if (sgn) begin
            ia = a; ib = b;
            sa = ia; sb = ib;
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic scramble();
        dividend_i = $urandom;
        divisor_i  = $urandom;
        signed_i   = 1'($urandom_range(0, 1));
    endtask

    task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input int annul_at, input int hold);
        logic [63:0] exp;
        int lat;
        exp = model(sgn, a, b);
        lat = (b == 0) ? 2 : W + 1;
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b0; signed_i = sgn; dividend_i = a; divisor_i = b;
        #1;
        check("stall_c0", stallreq_o, 1);
        check("ready_c0", ready_o, 0);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            scramble();
            if (k == annul_at) begin
                start_i = 1'b0; annul_i = 1'b1;
                #1;
                check("stall_annul", stallreq_o, 0);
                for (int j = 0; j < 36; j++) begin
                    @(negedge clk);
                    annul_i = 1'b0;
                    scramble();
                    #1;
                    check("ready_after_annul", ready_o, 0);
                    check("stall_after_annul", stallreq_o, 0);
                end
                return;
            end
            #1;
            check("stall_busy", stallreq_o, 1);
            check("ready_busy", ready_o, 0);
        end
        @(negedge clk);
        scramble();
        #1;
        check("ready_end", ready_o, 1);
        check("stall_end", stallreq_o, 0);
        check("result", result_o, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            annul_i = 1'($urandom_range(0, 1));
            scramble();
            #1;
            check("ready_hold", ready_o, 1);
            check("result_hold", result_o, exp);
            check("stall_hold", stallreq_o, 0);
        end
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        #1;
        check("ready_drop", ready_o, 1);
        check("stall_drop", stallreq_o, 0);
        @(negedge clk);
        #1;
        check("ready_free", ready_o, 0);
        check("result_free", result_o, 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit rs;
        int aat;
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
        dividend_i = '0; divisor_i = '0;
        @(negedge clk);
        #1;
        check("rst_ready", ready_o, 0);
        check("rst_result", result_o, 0);
        check("rst_stall", stallreq_o, 0);
        @(negedge clk);
        rst = 1'b1;

        do_div(1'b0, 32'd100, 32'd7, -1, 0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, -1, 1);
        do_div(1'b1, 32'h1234, 32'd0, -1, 1);
        do_div(1'b0, 32'h1234, 32'd0, -1, 1);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd3, 10, 0);
        do_div(1'b0, 32'd9, 32'd3, -1, 0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 5);
        do_div(1'b0, 32'd5, 32'd0, 1, 0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, -1, 0);
        do_div(1'b0, 32'd3, 32'hFFFF_FFFF, -1, 0);

        // annul in FREE blocks acceptance
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5;
        #1;
        check("stall_annul_free", stallreq_o, 0);
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        for (int j = 0; j < 36; j++) begin
            @(negedge clk);
            #1;
            check("ready_no_accept", ready_o, 0);
        end

        // reset between edges in the middle of an operation
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
        for (int k = 1; k <= 15; k++) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_on_ready", ready_o, 0);
        check("rst_on_result", result_o, 0);
        check("rst_on_stall", stallreq_o, 0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, -1, 0);

        // reset while a result is held in END
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
        for (int k = 1; k <= W + 1; k++) @(negedge clk);
        #1;
        check("pre_rst_ready", ready_o, 1);
        check("pre_rst_result", result_o, {32'd2, 32'd14});
        #1 rst = 1'b0;
        #1;
        check("rst_end_ready", ready_o, 0);
        check("rst_end_result", result_o, 0);
        check("rst_end_stall", stallreq_o, 0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 20);
                2: rb = 32'hFFFF_FFFF - $urandom_range(0, 20);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 100);
            aat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 32)) : -1;
            do_div(rs, ra, rb, aat, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
